// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with START/BUSY/DONE handshake and status flags.
// Define ALU_MUL_EN to build the WIDTH-cycle shift-add multiplier for OP=111.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             START,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] S_HI,
   output logic             CF,
   output logic             ZF,
   output logic             NF,
   output logic             VF,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {IDLE, EXEC} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             cf;
      logic             vf;
   } alu_res_t;

   // SUB reuses the adder as A + ~B + 1, so CF=1 means no borrow.
   function automatic alu_res_t alu_eval(input logic [2:0]       op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
      alu_res_t         r;
      logic [WIDTH-1:0] b_eff;
      logic [WIDTH:0]   sum;
      r     = '0;
      b_eff = (op == OP_SUB) ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
      case (op)
         OP_ADD, OP_SUB: begin
            r.s  = sum[WIDTH-1:0];
            r.cf = sum[WIDTH];
            r.vf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: r.s = a & b;
         OP_OR:  r.s = a | b;
         OP_XOR: r.s = a ^ b;
         OP_SHL: begin
            r.s  = {a[WIDTH-2:0], 1'b0};
            r.cf = a[WIDTH-1];
         end
         OP_SHR: begin
            r.s  = {1'b0, a[WIDTH-1:1]};
            r.cf = a[0];
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   state_t           state;
   logic [2:0]       op_p0;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   alu_res_t         res;

   assign res = alu_eval(op_p0, a_p0, b_p0);

`ifdef ALU_MUL_EN
   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] mul_cnt;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH:0]   mul_add;
   logic [WIDTH-1:0] mul_hi_nxt;
   logic [WIDTH-1:0] mul_lo_nxt;
   logic [WIDTH-1:0] s_hi_q;

   // Right-shifting product register: multiplier bits leave mul_lo LSB first
   // while product bits enter from the top.
   always_comb begin
      mul_add    = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, a_p0} : {(WIDTH+1){1'b0}});
      mul_hi_nxt = mul_add[WIDTH:1];
      mul_lo_nxt = {mul_add[0], mul_lo[WIDTH-1:1]};
   end

   assign S_HI = s_hi_q;
`else
   assign S_HI = '0;
`endif

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state <= IDLE;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         S     <= '0;
         CF    <= 1'b0;
         ZF    <= 1'b0;
         NF    <= 1'b0;
         VF    <= 1'b0;
`ifdef ALU_MUL_EN
         s_hi_q <= '0;
`endif
      end else begin
         case (state)
            // accept stage: operands captured here are the only ones used
            IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  op_p0 <= OP;
                  a_p0  <= A;
                  b_p0  <= B;
                  BUSY  <= 1'b1;
                  state <= EXEC;
`ifdef ALU_MUL_EN
                  mul_hi  <= '0;
                  mul_lo  <= B;
                  mul_cnt <= '0;
`endif
               end
            end
            // execute stage: results and flags only change on completion
            EXEC: begin
`ifdef ALU_MUL_EN
               if (op_p0 == OP_MUL) begin
                  mul_hi  <= mul_hi_nxt;
                  mul_lo  <= mul_lo_nxt;
                  mul_cnt <= mul_cnt + 1'b1;
                  if (mul_cnt == CNT_LAST) begin
                     S      <= mul_lo_nxt;
                     s_hi_q <= mul_hi_nxt;
                     CF     <= |mul_hi_nxt;
                     VF     <= |mul_hi_nxt;
                     ZF     <= ~|{mul_hi_nxt, mul_lo_nxt};
                     NF     <= 1'b0;
                     DONE   <= 1'b1;
                     BUSY   <= 1'b0;
                     state  <= IDLE;
                  end
               end else begin
                  s_hi_q <= '0;
`else
               begin
`endif
                  S     <= res.s;
                  CF    <= res.cf;
                  VF    <= res.vf;
                  ZF    <= (res.s == '0);
                  NF    <= res.s[WIDTH-1];
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
